// File: rtl/mem_scheduler.sv
// Shared-memory scheduler: fetch, data and optional DMA request ports arbitrated onto one memory bus.
// Define MEM_SCHED_DMA_EN to compile in the third, lowest-priority DMA port.
module mem_scheduler #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_mem_valid,
    input  logic        imem_mem_instr,
    input  logic [31:0] imem_mem_addr,
    input  logic [31:0] imem_mem_wdata,
    input  logic [3:0]  imem_mem_wstrb,
    output logic [31:0] imem_mem_rdata,
    output logic        imem_mem_ready,
    input  logic        dmem_mem_valid,
    input  logic        dmem_mem_instr,
    input  logic [31:0] dmem_mem_addr,
    input  logic [31:0] dmem_mem_wdata,
    input  logic [3:0]  dmem_mem_wstrb,
    output logic [31:0] dmem_mem_rdata,
    output logic        dmem_mem_ready,
`ifdef MEM_SCHED_DMA_EN
    input  logic        dma_mem_valid,
    input  logic        dma_mem_instr,
    input  logic [31:0] dma_mem_addr,
    input  logic [31:0] dma_mem_wdata,
    input  logic [3:0]  dma_mem_wstrb,
    output logic [31:0] dma_mem_rdata,
    output logic        dma_mem_ready,
`endif
    output logic        memory_valid,
    output logic        memory_instr,
    output logic [31:0] memory_addr,
    output logic [31:0] memory_wdata,
    output logic [3:0]  memory_wstrb,
    input  logic [31:0] memory_rdata,
    input  logic        memory_ready,
    output logic        sched_err
);

    typedef struct packed {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    typedef enum logic [1:0] {IDLE, GRANT_IMEM, GRANT_DMEM, GRANT_DMA} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state;
    req_t       bus;
    req_t       slot_i, slot_d, slot_a;
    req_t       req_i, req_d, req_a;
    req_t       next_i, next_d, next_a;
    logic       pend_i, pend_d, pend_a;
    logic       valid_a;
    logic [3:0] starve_cnt;
    logic       done_i, done_d, done_a;
    logic       cap_i, cap_d, cap_a;
    logic       want_i, want_d, want_a;
    logic       sel_i, sel_d, sel_a;
    logic       decide, drop;

    assign req_i = {imem_mem_instr, imem_mem_addr, imem_mem_wdata, imem_mem_wstrb};
    assign req_d = {dmem_mem_instr, dmem_mem_addr, dmem_mem_wdata, dmem_mem_wstrb};

`ifdef MEM_SCHED_DMA_EN
    assign valid_a       = dma_mem_valid;
    assign req_a         = {dma_mem_instr, dma_mem_addr, dma_mem_wdata, dma_mem_wstrb};
    assign dma_mem_ready = done_a;
    assign dma_mem_rdata = done_a ? memory_rdata : '0;
`else
    assign valid_a = 1'b0;
    assign req_a   = '0;
`endif

    // A port completes in the cycle the bus acknowledges its grant; that slot may be refilled then.
    assign done_i = (state == GRANT_IMEM) && memory_ready;
    assign done_d = (state == GRANT_DMEM) && memory_ready;
    assign done_a = (state == GRANT_DMA)  && memory_ready;

    assign cap_i = imem_mem_valid && (!pend_i || done_i);
    assign cap_d = dmem_mem_valid && (!pend_d || done_d);
    assign cap_a = valid_a        && (!pend_a || done_a);

    assign drop = (imem_mem_valid && pend_i && !done_i) ||
                  (dmem_mem_valid && pend_d && !done_d) ||
                  (valid_a        && pend_a && !done_a);

    // Pending view after this edge: surviving requests plus same-cycle captures.
    assign want_i = cap_i || (pend_i && !done_i);
    assign want_d = cap_d || (pend_d && !done_d);
    assign want_a = cap_a || (pend_a && !done_a);

    assign next_i = cap_i ? req_i : slot_i;
    assign next_d = cap_d ? req_d : slot_d;
    assign next_a = cap_a ? req_a : slot_a;

    assign decide = (state == IDLE) || memory_ready;
    assign sel_i  = want_i && (!want_d || (starve_cnt == LIMIT));
    assign sel_d  = want_d && !sel_i;
    assign sel_a  = want_a && !want_i && !want_d;

    assign imem_mem_ready = done_i;
    assign imem_mem_rdata = done_i ? memory_rdata : '0;
    assign dmem_mem_ready = done_d;
    assign dmem_mem_rdata = done_d ? memory_rdata : '0;

    assign memory_instr = bus.instr;
    assign memory_addr  = bus.addr;
    assign memory_wdata = bus.wdata;
    assign memory_wstrb = bus.wstrb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            bus          <= '0;
            memory_valid <= 1'b0;
            pend_i       <= 1'b0;
            pend_d       <= 1'b0;
            pend_a       <= 1'b0;
            // NOTE: the request slots are reset as well; they are only a few flops and keep X off the bus.
            slot_i       <= '0;
            slot_d       <= '0;
            slot_a       <= '0;
            starve_cnt   <= '0;
            sched_err    <= 1'b0;
        end else begin
            pend_i <= want_i;
            pend_d <= want_d;
            pend_a <= want_a;
            slot_i <= next_i;
            slot_d <= next_d;
            slot_a <= next_a;
            if (drop) sched_err <= 1'b1;
            if (decide) begin
                memory_valid <= sel_i || sel_d || sel_a;
                if (sel_i) begin
                    state      <= GRANT_IMEM;
                    bus        <= next_i;
                    starve_cnt <= '0;
                end else if (sel_d) begin
                    state      <= GRANT_DMEM;
                    bus        <= next_d;
                    starve_cnt <= want_i ? starve_cnt + 4'd1 : 4'd0;
                end else if (sel_a) begin
                    state      <= GRANT_DMA;
                    bus        <= next_a;
                    starve_cnt <= '0;
                end else begin
                    state      <= IDLE;
                    starve_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_scheduler.sv
// Directed self-checking bench for mem_scheduler with a simple wait-state memory model and a response monitor.
// Define MEM_SCHED_DMA_EN to also exercise the DMA port.
module tb_mem_scheduler;

    logic        clk;
    logic        rst;
    logic        imem_mem_valid, imem_mem_instr;
    logic [31:0] imem_mem_addr, imem_mem_wdata, imem_mem_rdata;
    logic [3:0]  imem_mem_wstrb;
    logic        imem_mem_ready;
    logic        dmem_mem_valid, dmem_mem_instr;
    logic [31:0] dmem_mem_addr, dmem_mem_wdata, dmem_mem_rdata;
    logic [3:0]  dmem_mem_wstrb;
    logic        dmem_mem_ready;
    logic        dma_mem_valid, dma_mem_instr;
    logic [31:0] dma_mem_addr, dma_mem_wdata, dma_mem_rdata;
    logic [3:0]  dma_mem_wstrb;
    logic        dma_mem_ready;
    logic        memory_valid, memory_instr;
    logic [31:0] memory_addr, memory_wdata, memory_rdata;
    logic [3:0]  memory_wstrb;
    logic        memory_ready;
    logic        sched_err;

    mem_scheduler #(.STARVE_LIMIT(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_mem_valid (imem_mem_valid),
        .imem_mem_instr (imem_mem_instr),
        .imem_mem_addr  (imem_mem_addr),
        .imem_mem_wdata (imem_mem_wdata),
        .imem_mem_wstrb (imem_mem_wstrb),
        .imem_mem_rdata (imem_mem_rdata),
        .imem_mem_ready (imem_mem_ready),
        .dmem_mem_valid (dmem_mem_valid),
        .dmem_mem_instr (dmem_mem_instr),
        .dmem_mem_addr  (dmem_mem_addr),
        .dmem_mem_wdata (dmem_mem_wdata),
        .dmem_mem_wstrb (dmem_mem_wstrb),
        .dmem_mem_rdata (dmem_mem_rdata),
        .dmem_mem_ready (dmem_mem_ready),
`ifdef MEM_SCHED_DMA_EN
        .dma_mem_valid  (dma_mem_valid),
        .dma_mem_instr  (dma_mem_instr),
        .dma_mem_addr   (dma_mem_addr),
        .dma_mem_wdata  (dma_mem_wdata),
        .dma_mem_wstrb  (dma_mem_wstrb),
        .dma_mem_rdata  (dma_mem_rdata),
        .dma_mem_ready  (dma_mem_ready),
`endif
        .memory_valid   (memory_valid),
        .memory_instr   (memory_instr),
        .memory_addr    (memory_addr),
        .memory_wdata   (memory_wdata),
        .memory_wstrb   (memory_wstrb),
        .memory_rdata   (memory_rdata),
        .memory_ready   (memory_ready),
        .sched_err      (sched_err)
    );

`ifndef MEM_SCHED_DMA_EN
    assign dma_mem_rdata = '0;
    assign dma_mem_ready = 1'b0;
`endif

    typedef struct {
        int          port;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        int          cyc;
    } entry_t;

    entry_t log_q[$];
    int     vectors = 0;
    int     miscompares = 0;
    int     wait_cycles = 0;
    int     cyc = 0;
    int     vcyc = 0;
    int     rc_i = 0, rc_d = 0, rc_a = 0;
    int     misroute = 0;
    int     unstable = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model_rdata(input logic [31:0] a);
        return (a == 32'h0000_0100) ? 32'h0000_0013 : (a ^ 32'h5A5A_5A5A);
    endfunction

    // Memory model: acknowledges after wait_cycles wait states; rdata is garbage outside ready.
    initial begin
        int wcnt;
        wcnt         = 0;
        memory_ready = 1'b0;
        memory_rdata = 32'hFFFF_FFFF;
        forever begin
            @(posedge clk);
            #1;
            memory_ready = 1'b0;
            memory_rdata = 32'hFFFF_FFFF;
            if (rst || !memory_valid) begin
                wcnt = 0;
            end else if (wcnt >= wait_cycles) begin
                memory_ready = 1'b1;
                memory_rdata = model_rdata(memory_addr);
                wcnt         = 0;
            end else begin
                wcnt++;
            end
        end
    end

    // Monitor: logs every port response with the bus contents, and counts routing/stability errors.
    initial begin
        logic   hold;
        entry_t e;
        entry_t prev;
        hold = 1'b0;
        prev = '{default: 0};
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (memory_valid) vcyc++;
            if ((32'(imem_mem_ready) + 32'(dmem_mem_ready) + 32'(dma_mem_ready)) > 1) misroute++;
            if (!imem_mem_ready && imem_mem_rdata != 0) misroute++;
            if (!dmem_mem_ready && dmem_mem_rdata != 0) misroute++;
            if (!dma_mem_ready  && dma_mem_rdata  != 0) misroute++;
            e = '{port: 0, instr: memory_instr, addr: memory_addr, wdata: memory_wdata,
                  wstrb: memory_wstrb, rdata: 0, cyc: cyc};
            if (imem_mem_ready) begin
                rc_i++; e.port = 1; e.rdata = imem_mem_rdata; log_q.push_back(e);
            end
            if (dmem_mem_ready) begin
                rc_d++; e.port = 2; e.rdata = dmem_mem_rdata; log_q.push_back(e);
            end
            if (dma_mem_ready) begin
                rc_a++; e.port = 3; e.rdata = dma_mem_rdata; log_q.push_back(e);
            end
            if (hold && memory_valid &&
                (memory_addr != prev.addr || memory_wdata != prev.wdata ||
                 memory_wstrb != prev.wstrb || memory_instr != prev.instr))
                unstable++;
            hold = memory_valid && !memory_ready && !rst;
            prev = e;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        log_q.delete();
        vcyc = 0;
        rc_i = 0;
        rc_d = 0;
        rc_a = 0;
    endtask

    // One-cycle pulse on any combination of ports; returns 1 time unit after the capture edge.
    task automatic issue(input logic vi, input logic [31:0] ai,
                         input logic vd, input logic [31:0] ad, input logic [31:0] wd, input logic [3:0] sd,
                         input logic va, input logic [31:0] aa);
        @(posedge clk);
        #1;
        imem_mem_valid = vi; imem_mem_instr = 1'b1; imem_mem_addr = ai;
        imem_mem_wdata = '0; imem_mem_wstrb = '0;
        dmem_mem_valid = vd; dmem_mem_instr = 1'b0; dmem_mem_addr = ad;
        dmem_mem_wdata = wd; dmem_mem_wstrb = sd;
        dma_mem_valid  = va; dma_mem_instr  = 1'b0; dma_mem_addr  = aa;
        dma_mem_wdata  = '0; dma_mem_wstrb  = '0;
        @(posedge clk);
        #1;
        imem_mem_valid = 1'b0;
        dmem_mem_valid = 1'b0;
        dma_mem_valid  = 1'b0;
    endtask

    task automatic wait_log(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (log_q.size() < n && k < budget) begin
            @(posedge clk);
            #3;
            k++;
        end
        check(tag, 32'(log_q.size()), 32'(n));
    endtask

    task automatic check_entry(input string tag, input int idx, input int port, input logic [31:0] addr,
                               input logic instr, input logic [31:0] wdata, input logic [3:0] wstrb);
        entry_t e;
        e = '{default: 0};
        if (idx < log_q.size()) e = log_q[idx];
        check({tag, ".port"},  32'(e.port), 32'(port));
        check({tag, ".addr"},  e.addr, addr);
        check({tag, ".instr"}, 32'(e.instr), 32'(instr));
        check({tag, ".wdata"}, e.wdata, wdata);
        check({tag, ".wstrb"}, 32'(e.wstrb), 32'(wstrb));
        check({tag, ".rdata"}, e.rdata, model_rdata(addr));
    endtask

    initial begin
        int          issued;
        int          k;
        int          exp_port[7];
        entry_t      e;

        rst = 1'b1;
        imem_mem_valid = 1'b0; imem_mem_instr = 1'b0; imem_mem_addr = '0; imem_mem_wdata = '0; imem_mem_wstrb = '0;
        dmem_mem_valid = 1'b0; dmem_mem_instr = 1'b0; dmem_mem_addr = '0; dmem_mem_wdata = '0; dmem_mem_wstrb = '0;
        dma_mem_valid  = 1'b0; dma_mem_instr  = 1'b0; dma_mem_addr  = '0; dma_mem_wdata  = '0; dma_mem_wstrb  = '0;

        // Reset state
        #3;
        check("rst.valid", 32'(memory_valid), 0);
        check("rst.instr", 32'(memory_instr), 0);
        check("rst.addr",  memory_addr, 0);
        check("rst.wdata", memory_wdata, 0);
        check("rst.wstrb", 32'(memory_wstrb), 0);
        check("rst.i_ready", 32'(imem_mem_ready), 0);
        check("rst.i_rdata", imem_mem_rdata, 0);
        check("rst.d_ready", 32'(dmem_mem_ready), 0);
        check("rst.d_rdata", dmem_mem_rdata, 0);
        check("rst.err", 32'(sched_err), 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst.valid", 32'(memory_valid), 0);

        // Single fetch, two wait states
        clear_stats();
        wait_cycles = 2;
        issue(1'b1, 32'h100, 1'b0, 0, 0, 4'h0, 1'b0, 0);
        check("fetch.first_valid", 32'(memory_valid), 1);
        check("fetch.first_instr", 32'(memory_instr), 1);
        check("fetch.first_addr",  memory_addr, 32'h100);
        wait_log("fetch.done", 1, 20);
        check_entry("fetch", 0, 1, 32'h100, 1'b1, 0, 4'h0);
        check("fetch.rdata_lit", log_q.size() > 0 ? log_q[0].rdata : 0, 32'h0000_0013);
        check("fetch.valid_cycles", 32'(vcyc), 3);
        repeat (3) @(posedge clk);
        #3;
        check("fetch.i_pulses", 32'(rc_i), 1);

        // Same-cycle imem read + dmem write, zero-wait memory
        clear_stats();
        wait_cycles = 0;
        issue(1'b1, 32'h104, 1'b1, 32'h2000, 32'hDEAD_BEEF, 4'hF, 1'b0, 0);
        wait_log("pair.done", 2, 20);
        check_entry("pair0", 0, 2, 32'h2000, 1'b0, 32'hDEAD_BEEF, 4'hF);
        check_entry("pair1", 1, 1, 32'h104, 1'b1, 0, 4'h0);
        if (log_q.size() >= 2) check("pair.no_gap", 32'(log_q[1].cyc - log_q[0].cyc), 1);
        else check("pair.no_gap", 32'(log_q.size()), 2);
        repeat (3) @(posedge clk);
        #3;
        check("pair.valid_cycles", 32'(vcyc), 2);
        check("pair.i_pulses", 32'(rc_i), 1);
        check("pair.d_pulses", 32'(rc_d), 1);

        // Starvation: dmem re-issued at every dmem completion while imem waits
        clear_stats();
        wait_cycles = 1;
        issued = 1;
        issue(1'b1, 32'h108, 1'b1, 32'h3000, 0, 4'h0, 1'b0, 0);
        k = 0;
        while (log_q.size() < 7 && k < 100) begin
            #1;
            if (dmem_mem_ready && issued < 6) begin
                dmem_mem_valid = 1'b1;
                dmem_mem_addr  = 32'h3000 + 32'(4 * issued);
                dmem_mem_wstrb = 4'h0;
                dmem_mem_wdata = '0;
                issued++;
            end
            @(posedge clk);
            #1;
            dmem_mem_valid = 1'b0;
            k++;
        end
        repeat (5) @(posedge clk);
        #3;
        check("starve.count", 32'(log_q.size()), 7);
        exp_port = '{2, 2, 2, 2, 1, 2, 2};
        for (int i = 0; i < 7; i++) begin
            e = '{default: 0};
            if (i < log_q.size()) e = log_q[i];
            check($sformatf("starve.port%0d", i), 32'(e.port), 32'(exp_port[i]));
        end
        check_entry("starve3", 3, 2, 32'h300C, 1'b0, 0, 4'h0);
        check_entry("starve4", 4, 1, 32'h108, 1'b1, 0, 4'h0);
        check_entry("starve5", 5, 2, 32'h3010, 1'b0, 0, 4'h0);
        check("starve.err_clear", 32'(sched_err), 0);

        // Protocol violation: second dmem pulse while the first is still pending
        clear_stats();
        wait_cycles = 3;
        issue(1'b0, 0, 1'b1, 32'h4000, 0, 4'h0, 1'b0, 0);
        check("viol.err_before", 32'(sched_err), 0);
        issue(1'b0, 0, 1'b1, 32'h5000, 32'h1234_5678, 4'h3, 1'b0, 0);
        check("viol.err_set", 32'(sched_err), 1);
        wait_log("viol.done", 1, 30);
        check_entry("viol", 0, 2, 32'h4000, 1'b0, 0, 4'h0);
        repeat (6) @(posedge clk);
        #3;
        check("viol.dropped", 32'(log_q.size()), 1);
        check("viol.err_sticky", 32'(sched_err), 1);

        // Reset in the middle of a granted access
        clear_stats();
        wait_cycles = 5;
        issue(1'b1, 32'h200, 1'b0, 0, 0, 4'h0, 1'b0, 0);
        @(posedge clk);
        #3;
        check("mid.in_grant", 32'(memory_valid), 1);
        rst = 1'b1;
        #1;
        check("mid.valid_drop", 32'(memory_valid), 0);
        check("mid.addr_drop", memory_addr, 0);
        check("mid.err_clear", 32'(sched_err), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid.stay_idle", 32'(memory_valid), 0);
        check("mid.no_resp", 32'(log_q.size()), 0);
        wait_cycles = 0;
        issue(1'b1, 32'h300, 1'b0, 0, 0, 4'h0, 1'b0, 0);
        wait_log("mid.after", 1, 20);
        check_entry("mid_after", 0, 1, 32'h300, 1'b1, 0, 4'h0);

`ifdef MEM_SCHED_DMA_EN
        // DMA and imem together: imem first, then DMA
        clear_stats();
        wait_cycles = 0;
        issue(1'b1, 32'h500, 1'b0, 0, 0, 4'h0, 1'b1, 32'h600);
        wait_log("dma.done", 2, 20);
        check_entry("dma0", 0, 1, 32'h500, 1'b1, 0, 4'h0);
        check_entry("dma1", 1, 3, 32'h600, 1'b0, 0, 4'h0);
        repeat (3) @(posedge clk);
        #3;
        check("dma.a_pulses", 32'(rc_a), 1);
`endif

        check("misroute", 32'(misroute), 0);
        check("bus_stable", 32'(unstable), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_scheduler.md
# mem_scheduler

Shared-memory scheduler between the core's instruction-fetch port, its data port and, optionally, a DMA port. It drives one external memory bus. Each port's request is captured into a pending slot. One pending request at a time is granted and held on the bus until the memory acknowledges it, and the response is routed back to the owning port. It sits between the fetch buffer / decode-execute memory ports and the top-level memory pins.

## Interface
- STARVE_LIMIT, default 4: consecutive data-port grants allowed while a fetch request waits; range 1..15.
- rst  in  1  reset; asynchronous, active-high.
- clk  in  1  clock; single clock, all state on its rising edge.
- imem_in  in  mem_in_type  fetch request.
  - Fields: mem_valid, mem_instr, mem_addr[31:0], mem_wdata[31:0], mem_wstrb[3:0].
- imem_out  out  mem_out_type  fetch response.
  - Fields: mem_rdata[31:0], mem_ready.
- dmem_in  in  mem_in_type  data-port request.
- dmem_out  out  mem_out_type  data-port response.
- dma_in  in  mem_in_type  DMA request; present only with MEM_SCHED_DMA_EN.
- dma_out  out  mem_out_type  DMA response; present only with MEM_SCHED_DMA_EN.
- memory_valid  out  1  bus request.
- memory_instr  out  1  bus request is an instruction fetch.
- memory_addr  out  32  bus address.
- memory_wdata  out  32  bus write data.
- memory_wstrb  out  4  bus byte strobes; 0 means read.
- memory_rdata  in  32  bus read data.
- memory_ready  in  1  bus acknowledge.
- sched_err  out  1  sticky protocol-violation flag.

## Operation
- **Request capture**
  - A port's mem_valid high for one cycle captures instr/addr/wdata/wstrb into that port's pending slot and sets its pend bit.
  - If pend is already set, the new request is dropped, the slot is unchanged and sched_err is set.
  - sched_err clears only on reset.
  - In a port's completion cycle, a new mem_valid on that port is captured, not flagged.
- **State machine**
  - IDLE → GRANT(p) at the edge where any pend bit is set (including one captured that same cycle). Granted port p is chosen by the arbitration rules below.
  - GRANT(p) → GRANT(q) at the memory_ready edge if another pend bit is set.
  - GRANT(p) → IDLE at the memory_ready edge otherwise.
- **Arbitration priority:** dmem > imem > dma.
  - Starvation counter, 4 bits: increments on each dmem grant made while imem pend is set.
  - Counter clears on any imem grant, or when imem pend is clear.
  - At counter == STARVE_LIMIT, imem takes priority over dmem.
  - dma is granted only when both other pend bits are clear.
- **Bus drive**
  - In GRANT(p), memory_* outputs are registered copies of slot p, held stable until memory_ready.
  - memory_valid is high exactly while in GRANT.
- **Response routing**
  - In the memory_ready cycle, p_out.mem_ready = 1 and p_out.mem_rdata = memory_rdata, combinationally.
  - p's pend bit clears at that edge.
  - All other ports' mem_ready = 0; their mem_rdata = 0.
- memory_ready seen while in IDLE is ignored.

## Timing
- **Reset values**
  - memory_valid, memory_instr = 0; memory_addr, memory_wdata = 0; memory_wstrb = 0.
  - All mem_ready = 0; all mem_rdata = 0; sched_err = 0.
  - Pend bits clear, state IDLE, starvation counter 0.
- **Latency:** request captured at edge T, bus idle → memory_valid high from T+1.
  - With a zero-wait memory (ready in the first valid cycle), the port sees mem_ready in cycle T+1.
- **Back-to-back:** on the ready edge, the next pending request appears on the bus in the following cycle, so memory_valid stays high with no bubble.
- **Simultaneous valid on several ports:** all are captured in the same edge; the grant order follows the priority rules.
- **Reset mid-transaction:** asynchronous; outputs go to reset values immediately and the outstanding bus access is abandoned.
  - The external memory must also be in reset.

## Configuration
- MEM_SCHED_DMA_EN defined:
  - The dma_in/dma_out ports, the third pending slot and lowest-priority grant are compiled in.
- MEM_SCHED_DMA_EN undefined:
  - The DMA ports and slot are absent and arbitration is two-way, imem/dmem only.
  - Behaviour is otherwise identical.

## Test plan
- **Single fetch:** imem pulse with addr 0x100, memory_ready after 2 wait cycles, rdata 0x00000013.
  - memory_valid high for 3 cycles with memory_instr=1, addr=0x100.
  - imem_out.mem_ready pulses once with 0x00000013.
- **Same-cycle imem + dmem:** dmem is a write to 0x2000 with data 0xDEADBEEF, wstrb 0xF.
  - The dmem write is bussed first, then the imem read back-to-back with no memory_valid gap.
  - Each port gets exactly one ready pulse.
- **Starvation, STARVE_LIMIT=4:** dmem requests re-issued every completion while imem stays pending.
  - imem is granted after exactly 4 dmem grants.
- **Protocol violation:** second dmem pulse while dmem is pending.
  - The request is dropped, sched_err=1 and stays set.
  - The original request completes normally.
- **Reset mid-transaction:** rst asserted while in GRANT.
  - memory_valid is 0 within the same cycle and all pend bits clear.
  - A new imem request after reset completes normally.
- **DMA (with MEM_SCHED_DMA_EN):** dma and imem pulse together.
  - imem is served first, then dma.
  - dma_out.mem_ready pulses with the dma read data.
